// File: rtl/vector_exec_sequencer.sv
// vector_exec_sequencer: runs one vector instruction in EX over P shared lane
// ALUs, P elements per pass, and assembles the truncated lane results into a
// result vector. Holds the upstream pipes via stall_o and enables EX_MEM via
// ready_o.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   start_i           ID_EX holds a valid instruction
//   OpType_i          00 scalar, 01 vec-vec, 10 vec-scalar, 11 scalar
//   flush_i           abort the current op (highest priority)
//   RD1_V_i, RD2_V_i  vector operands, element k at [k*L +: L]
//   Scalar_i          scalar operand for vec-scalar
//   lane_res_i        combinational lane ALU results, lane j at [j*N +: N]
//   Vec_A_o, Vec_B_o  lane operands (zero-extended elements)
//   lane_vld_o        lane carries a real element this cycle
//   result_V_o        assembled vector result
//   ready_o, stall_o  EX result valid / hold upstream pipes
//   perf_busy_o       RUN cycle count (EXE_SEQ_PERF_EN only, else 0)
//   perf_ops_o        completed vector ops (EXE_SEQ_PERF_EN only, else 0)
//
// Optional feature macro: EXE_SEQ_PERF_EN builds the performance counters.
module vector_exec_sequencer #(
  parameter int unsigned N = 32,
  parameter int unsigned L = 8,
  parameter int unsigned I = 8,
  parameter int unsigned P = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic [1:0]     OpType_i,
  input  logic           flush_i,
  input  logic [I*L-1:0] RD1_V_i,
  input  logic [I*L-1:0] RD2_V_i,
  input  logic [N-1:0]   Scalar_i,
  input  logic [P*N-1:0] lane_res_i,
  output logic [P*N-1:0] Vec_A_o,
  output logic [P*N-1:0] Vec_B_o,
  output logic [P-1:0]   lane_vld_o,
  output logic [I*L-1:0] result_V_o,
  output logic           ready_o,
  output logic           stall_o,
  output logic [31:0]    perf_busy_o,
  output logic [15:0]    perf_ops_o
);

  localparam int unsigned VW = I * L;
  localparam int unsigned BW = $clog2(I + P) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   base_q, base_d;
  logic [VW-1:0]   a_q, b_q, result_q;
  logic            is_vec, accept, run_wr;

  // Only the low L bits of the scalar and lane results are architecturally used.
  logic unused_hi;
  assign unused_hi = ^{Scalar_i, lane_res_i};

  assign is_vec = (OpType_i == 2'b01) || (OpType_i == 2'b10);
  assign run_wr = (state_q == ST_RUN) && !flush_i;

  // State and pass-base registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Next state, accept strobe and pipeline handshake.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    accept  = 1'b0;
    ready_o = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && is_vec) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          base_d  = '0;
          state_d = ST_RUN;
        end else begin
          ready_o = 1'b1;
        end
      end
      ST_RUN: begin
        stall_o = 1'b1;
        base_d  = base_q + BW'(P);
        if (32'(base_q) + P >= I) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, reset forces the handshake low immediately.
    if (flush_i) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
      ready_o = 1'b0;
      stall_o = 1'b0;
    end
    if (!RST) begin
      ready_o = 1'b0;
      stall_o = 1'b0;
    end
  end

  // Operand capture; vec-scalar broadcasts the scalar's low element into B.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= RD1_V_i;
      b_q <= (OpType_i == 2'b10) ? {I{Scalar_i[L-1:0]}} : RD2_V_i;
    end
  end

  // Lane operand steering: lane j serves element base+j while it exists.
  always_comb begin
    Vec_A_o    = '0;
    Vec_B_o    = '0;
    lane_vld_o = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned j = 0; j < P; j++) begin
        if (32'(base_q) + j < I) begin
          Vec_A_o[j*N +: N] = N'(a_q[(32'(base_q) + j)*L +: L]);
          Vec_B_o[j*N +: N] = N'(b_q[(32'(base_q) + j)*L +: L]);
          lane_vld_o[j]     = 1'b1;
        end
      end
    end
  end

  // Result collection; untouched elements keep their previous value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_q <= '0;
    end else if (run_wr) begin
      for (int unsigned j = 0; j < P; j++) begin
        if (32'(base_q) + j < I)
          result_q[(32'(base_q) + j)*L +: L] <= lane_res_i[j*N +: L];
      end
    end
  end

  assign result_V_o = result_q;

`ifdef EXE_SEQ_PERF_EN
  logic [31:0] busy_q;
  logic [15:0] ops_q;

  // Free-running performance counters, cleared by reset only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= '0;
      ops_q  <= '0;
    end else begin
      if (state_q == ST_RUN) busy_q <= busy_q + 32'd1;
      if ((state_q == ST_DONE) && !flush_i) ops_q <= ops_q + 16'd1;
    end
  end

  assign perf_busy_o = busy_q;
  assign perf_ops_o  = ops_q;
`else
  assign perf_busy_o = '0;
  assign perf_ops_o  = '0;
`endif

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Self-checking bench: two sequencers (I=8 and I=6, P=4) driven by shared
// stimulus, each compared every cycle against a pass-counting transaction
// model, plus directed literal checks.
module tb_vector_exec_sequencer;

  logic         clk, rst_n, start, flush, sel;
  logic [1:0]   op;
  logic [63:0]  rd1, rd2;
  logic [31:0]  scalar;

  logic [127:0] a8, b8, lr8, a6, b6, lr6;
  logic [3:0]   vld8, vld6;
  logic [63:0]  res8;
  logic [47:0]  res6;
  logic         rdy8, stl8, rdy6, stl6;
  logic [31:0]  pb8, pb6;
  logic [15:0]  po8, po6;

  int checks = 0;
  int failures = 0;

  vector_exec_sequencer #(.N(32), .L(8), .I(8), .P(4)) u_dut8 (
    .CLK(clk), .RST(rst_n), .start_i(start), .OpType_i(op), .flush_i(flush),
    .RD1_V_i(rd1), .RD2_V_i(rd2), .Scalar_i(scalar), .lane_res_i(lr8),
    .Vec_A_o(a8), .Vec_B_o(b8), .lane_vld_o(vld8), .result_V_o(res8),
    .ready_o(rdy8), .stall_o(stl8), .perf_busy_o(pb8), .perf_ops_o(po8));

  vector_exec_sequencer #(.N(32), .L(8), .I(6), .P(4)) u_dut6 (
    .CLK(clk), .RST(rst_n), .start_i(start), .OpType_i(op), .flush_i(flush),
    .RD1_V_i(rd1[47:0]), .RD2_V_i(rd2[47:0]), .Scalar_i(scalar), .lane_res_i(lr6),
    .Vec_A_o(a6), .Vec_B_o(b6), .lane_vld_o(vld6), .result_V_o(res6),
    .ready_o(rdy6), .stall_o(stl6), .perf_busy_o(pb6), .perf_ops_o(po6));

  // Lane ALUs: add, or xor when sel is high.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lr8[j*32 +: 32] = sel ? (a8[j*32 +: 32] ^ b8[j*32 +: 32]) : (a8[j*32 +: 32] + b8[j*32 +: 32]);
      lr6[j*32 +: 32] = sel ? (a6[j*32 +: 32] ^ b6[j*32 +: 32]) : (a6[j*32 +: 32] + b6[j*32 +: 32]);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Transaction model: ph=0 idle, 1..np = pass number, np+1 = done cycle.
  int          ph [2];
  int          ni [2];
  logic [7:0]  ma [2][8];
  logic [7:0]  mb [2][8];
  logic [7:0]  mr [2][8];
  logic [31:0] mpb [2];
  logic [15:0] mpo [2];

  task automatic model_cmp(input int d, input logic [127:0] aa, input logic [127:0] ab,
                           input logic [3:0] av, input logic [63:0] ar, input logic ardy,
                           input logic astl, input logic [31:0] apb, input logic [15:0] apo);
    int np, e;
    bit vec, run, erdy, estl;
    logic [127:0] ea, eb;
    logic [3:0]   ev;
    logic [63:0]  er;
    np  = (ni[d] + 3) / 4;
    vec = start && (op == 2'b01 || op == 2'b10);
    if (!rst_n) begin
      ph[d] = 0; mpb[d] = '0; mpo[d] = '0;
      for (int k = 0; k < 8; k++) mr[d][k] = '0;
    end
    run = (ph[d] >= 1) && (ph[d] <= np);
    ea = '0; eb = '0; ev = '0; er = '0;
    if (run) begin
      for (int j = 0; j < 4; j++) begin
        e = (ph[d] - 1) * 4 + j;
        if (e < ni[d]) begin
          ea[j*32 +: 32] = {24'h0, ma[d][e]};
          eb[j*32 +: 32] = {24'h0, mb[d][e]};
          ev[j] = 1'b1;
        end
      end
    end
    for (int k = 0; k < ni[d]; k++) er[k*8 +: 8] = mr[d][k];
    erdy = rst_n && !flush && ((ph[d] == 0) ? !vec : (ph[d] == np + 1));
    estl = rst_n && !flush && ((ph[d] == 0) ? vec : run);
    chk($sformatf("d%0d vec_a", d), aa, ea);
    chk($sformatf("d%0d vec_b", d), ab, eb);
    chk($sformatf("d%0d lane_vld", d), {124'h0, av}, {124'h0, ev});
    chk($sformatf("d%0d result", d), {64'h0, ar}, {64'h0, er});
    chk($sformatf("d%0d ready", d), {127'h0, ardy}, {127'h0, erdy});
    chk($sformatf("d%0d stall", d), {127'h0, astl}, {127'h0, estl});
`ifdef EXE_SEQ_PERF_EN
    chk($sformatf("d%0d perf_busy", d), {96'h0, apb}, {96'h0, mpb[d]});
    chk($sformatf("d%0d perf_ops", d), {112'h0, apo}, {112'h0, mpo[d]});
`else
    chk($sformatf("d%0d perf_busy", d), {96'h0, apb}, 128'h0);
    chk($sformatf("d%0d perf_ops", d), {112'h0, apo}, 128'h0);
`endif
    if (rst_n) begin
      if (run && !flush) begin
        for (int j = 0; j < 4; j++) begin
          e = (ph[d] - 1) * 4 + j;
          if (e < ni[d]) mr[d][e] = sel ? (ma[d][e] ^ mb[d][e]) : (ma[d][e] + mb[d][e]);
        end
      end
      if (run) mpb[d] = mpb[d] + 32'd1;
      if ((ph[d] == np + 1) && !flush) mpo[d] = mpo[d] + 16'd1;
      if (flush) ph[d] = 0;
      else if (ph[d] == 0) begin
        if (vec) begin
          for (int k = 0; k < ni[d]; k++) begin
            ma[d][k] = rd1[k*8 +: 8];
            mb[d][k] = (op == 2'b10) ? scalar[7:0] : rd2[k*8 +: 8];
          end
          ph[d] = 1;
        end
      end else if (ph[d] == np + 1) ph[d] = 0;
      else ph[d] = ph[d] + 1;
    end
  endtask

  initial begin
    ni[0] = 8; ni[1] = 6;
    ph[0] = 0; ph[1] = 0;
  end

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    model_cmp(0, a8, b8, vld8, res8, rdy8, stl8, pb8, po8);
    model_cmp(1, a6, b6, vld6, {16'h0, res6}, rdy6, stl6, pb6, po6);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; flush = 1'b0; sel = 1'b0;
    rd1 = '0; rd2 = '0; scalar = '0;
    @(negedge clk);
    chk("reset ready", {127'h0, rdy8}, 128'h0);
    chk("reset stall", {127'h0, stl8}, 128'h0);
    chk("reset result", {64'h0, res8}, 128'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Scalar ops: zero latency, lanes idle.
    start = 1'b1; op = 2'b00;
    @(negedge clk);
    chk("scalar ready", {127'h0, rdy8}, 128'h1);
    chk("scalar stall", {127'h0, stl8}, 128'h0);
    chk("scalar vld", {124'h0, vld8}, 128'h0);
    cyc(); op = 2'b11;
    @(negedge clk);
    chk("op11 ready", {127'h0, rdy8}, 128'h1);
    cyc(); start = 1'b0;

    // Vec-vec add, A[k]=k, B[k]=2.
    for (int k = 0; k < 8; k++) begin
      rd1[k*8 +: 8] = 8'(k);
      rd2[k*8 +: 8] = 8'd2;
    end
    op = 2'b01; start = 1'b1;
    @(negedge clk);
    chk("vv accept stall", {127'h0, stl8}, 128'h1);
    chk("vv accept ready", {127'h0, rdy8}, 128'h0);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("vv run1 vld", {124'h0, vld8}, 128'hF);
    cyc();
    @(negedge clk);
    chk("vv run2 vld", {124'h0, vld8}, 128'hF);
    chk("partial vld", {124'h0, vld6}, 128'h3);
    chk("partial lanes23 A", {64'h0, a6[127:64]}, 128'h0);
    cyc();
    @(negedge clk);
    chk("vv done ready", {127'h0, rdy8}, 128'h1);
    chk("vv done stall", {127'h0, stl8}, 128'h0);
    chk("vv result", {64'h0, res8}, {64'h0, 64'h0908070605040302});
    chk("i6 result", {80'h0, res6}, {80'h0, 48'h070605040302});
    cyc();

    // Vec-scalar, truncation wrap.
    rd1 = '1; scalar = 32'h105; op = 2'b10; start = 1'b1;
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("vs lane B", b8, {4{32'h5}});
    cyc(); cyc();
    @(negedge clk);
    chk("vs result", {64'h0, res8}, {64'h0, 64'h0404040404040404});
    cyc();

    // Flush in the second RUN pass.
    rd1 = {$urandom, $urandom}; rd2 = {$urandom, $urandom}; op = 2'b01; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); flush = 1'b1;
    @(negedge clk);
    chk("flush ready", {127'h0, rdy8}, 128'h0);
    chk("flush stall", {127'h0, stl8}, 128'h0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    chk("post flush idle ready", {127'h0, rdy8}, 128'h1);
    chk("flush kept upper", {96'h0, res8[63:32]}, {96'h0, 32'h04040404});

    // Asynchronous reset in the middle of RUN.
    cyc(); op = 2'b01; start = 1'b1;
    cyc(); start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async rst result", {64'h0, res8}, 128'h0);
    chk("async rst vld", {124'h0, vld8}, 128'h0);
    chk("async rst stall", {127'h0, stl8}, 128'h0);
    chk("async rst vec_a", a8, 128'h0);
    chk("async rst perf_busy", {96'h0, pb8}, 128'h0);
    cyc(); rst_n = 1'b1;

    // Normal op after reset release.
    for (int k = 0; k < 8; k++) begin
      rd1[k*8 +: 8] = 8'(8'h10 + k);
      rd2[k*8 +: 8] = 8'h20;
    end
    op = 2'b01; start = 1'b1; sel = 1'b0;
    cyc(); start = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("post rst ready", {127'h0, rdy8}, 128'h1);
    chk("post rst result", {64'h0, res8}, {64'h0, 64'h3736353433323130});

    // Randomized traffic.
    repeat (800) begin
      cyc();
      start  = ($urandom % 3) != 0;
      op     = 2'($urandom % 4);
      flush  = ($urandom % 20) == 0;
      sel    = 1'($urandom % 2);
      rd1    = {$urandom, $urandom};
      rd2    = {$urandom, $urandom};
      scalar = $urandom;
    end
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
